busx_arbiter: RTL and testbench

Round-robin arbiter that merges N near-side bus masters onto the single near port of the BusX far-bus bridge. Sits directly upstream of BusX: masters present request/rw/address/wdata and hold request until ready. The arbiter grants one master, registers its command onto BusX, and routes the completion back. It serialises transactions so only one is ever outstanding at BusX.

---
 rtl/busx_pkg.sv | 10 +
 rtl/rr_picker.sv | 26 ++
 rtl/busx_arbiter.sv | 82 ++++++++
 tb/tb_busx_arbiter.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/busx_pkg.sv
// rtl/busx_pkg.sv - shared types and helpers for the BusX near-side arbiter
package busx_pkg;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// rtl/rr_picker.sv - combinational round-robin winner select starting at ptr
module rr_picker
  import busx_pkg::*;
#(
  parameter int N  = 2,
  parameter int GW = grant_w(N)
) (
  input  logic [N-1:0]  request,
  input  logic [GW-1:0] ptr,
  output logic          valid,
  output logic [GW-1:0] winner
);

  // Scan from the farthest offset down so the nearest requester at/after ptr wins.
  always_comb begin
    valid  = 1'b0;
    winner = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (request[(int'(ptr) + k) % N]) begin
        valid  = 1'b1;
        winner = GW'((int'(ptr) + k) % N);
      end
    end
  end

endmodule

// File: rtl/busx_arbiter.sv
// rtl/busx_arbiter.sv - round-robin merge of N masters onto the BusX near port
module busx_arbiter
  import busx_pkg::*;
#(
  parameter int NUM_MASTERS = 2,
  parameter int GW          = grant_w(NUM_MASTERS)
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic [NUM_MASTERS-1:0]    i_request,
  input  logic [NUM_MASTERS-1:0]    i_rw,
  input  logic [NUM_MASTERS*32-1:0] i_address,
  input  logic [NUM_MASTERS*32-1:0] i_wdata,
  output logic [31:0]               o_rdata,
  output logic [NUM_MASTERS-1:0]    o_ready,
  output logic                      o_bx_request,
  output logic                      o_bx_rw,
  output logic [31:0]               o_bx_address,
  output logic [31:0]               o_bx_wdata,
  input  logic [31:0]               i_bx_rdata,
  input  logic                      i_bx_ready,
  output logic [GW-1:0]             o_grant
);

  state_t        state;
  logic [GW-1:0] ptr;
  logic          pick_valid;
  logic [GW-1:0] pick_winner;

  rr_picker #(
    .N  (NUM_MASTERS),
    .GW (GW)
  ) u_picker (
    .request (i_request),
    .ptr     (ptr),
    .valid   (pick_valid),
    .winner  (pick_winner)
  );

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state        <= IDLE;
      ptr          <= '0;
      o_bx_request <= 1'b0;
      o_bx_rw      <= 1'b0;
      o_bx_address <= '0;
      o_bx_wdata   <= '0;
      o_grant      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            o_bx_request <= 1'b1;
            o_bx_rw      <= i_rw[pick_winner];
            o_bx_address <= i_address[32*int'(pick_winner) +: 32];
            o_bx_wdata   <= i_wdata[32*int'(pick_winner) +: 32];
            o_grant      <= pick_winner;
            state        <= BUSY;
          end
        end
        BUSY: begin
          // Command stays frozen until BusX completes, whatever the master does.
          if (i_bx_ready) begin
            o_bx_request <= 1'b0;
            if (o_grant == GW'(NUM_MASTERS - 1)) ptr <= '0;
            else                                 ptr <= o_grant + 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_ready = '0;
    if (state == BUSY && i_bx_ready) o_ready[o_grant] = 1'b1;
  end

  assign o_rdata = i_bx_rdata;

endmodule

// File: tb/tb_busx_arbiter.sv
// tb/tb_busx_arbiter.sv - self-checking bench for busx_arbiter with a BusX stub
module tb_busx_arbiter;

  localparam int N = 2;

  logic          i_clock;
  logic          i_reset;
  logic [N-1:0]  i_request;
  logic [N-1:0]  i_rw;
  logic [N*32-1:0] i_address;
  logic [N*32-1:0] i_wdata;
  logic [31:0]   o_rdata;
  logic [N-1:0]  o_ready;
  logic          o_bx_request;
  logic          o_bx_rw;
  logic [31:0]   o_bx_address;
  logic [31:0]   o_bx_wdata;
  logic [31:0]   i_bx_rdata;
  logic          i_bx_ready;
  logic [0:0]    o_grant;

  int checks = 0;
  int errors = 0;
  int model_ptr = 0;
  logic        m_rw[N];
  logic [31:0] m_addr[N];
  logic [31:0] m_wdata[N];

  busx_arbiter #(.NUM_MASTERS(N)) dut (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_request    (i_request),
    .i_rw         (i_rw),
    .i_address    (i_address),
    .i_wdata      (i_wdata),
    .o_rdata      (o_rdata),
    .o_ready      (o_ready),
    .o_bx_request (o_bx_request),
    .o_bx_rw      (o_bx_rw),
    .o_bx_address (o_bx_address),
    .o_bx_wdata   (o_bx_wdata),
    .i_bx_rdata   (i_bx_rdata),
    .i_bx_ready   (i_bx_ready),
    .o_grant      (o_grant)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  task automatic step();
    @(posedge i_clock);
    #1;
  endtask

  // Reference rule: lowest requesting index at or after ptr, wrapping to 0.
  function automatic int pick(input logic [N-1:0] req, input int p);
    for (int k = 0; k < N; k++)
      if (req[(p + k) % N]) return (p + k) % N;
    return -1;
  endfunction

  task automatic set_master(input int idx, input logic rw, input logic [31:0] addr,
                            input logic [31:0] data);
    m_rw[idx]    = rw;
    m_addr[idx]  = addr;
    m_wdata[idx] = data;
    i_rw[idx]    = rw;
    i_address[32*idx +: 32] = addr;
    i_wdata[32*idx +: 32]   = data;
    i_request[idx] = 1'b1;
  endtask

  task automatic do_reset();
    i_reset    = 1'b1;
    i_request  = '0;
    i_bx_ready = 1'b0;
    step();
    step();
    i_reset   = 1'b0;
    model_ptr = 0;
  endtask

  // Starts in an IDLE cycle with requests already driven; ends in the idle gap cycle.
  task automatic run_txn(input int delay, input logic [N-1:0] keep, input bit drop_mid,
                         input logic [31:0] rdata);
    int w;
    logic [N-1:0] exp_ready;
    w = pick(i_request, model_ptr);
    step();
    checks++;
    if (o_bx_request !== 1'b1) begin
      errors++;
      $display("FAIL bx_request_rise: got %b want 1", o_bx_request);
    end
    if (w < 0) return;
    checks++;
    if (o_grant !== 1'(w)) begin
      errors++;
      $display("FAIL grant: got %0d want %0d", o_grant, w);
    end
    checks++;
    if ({o_bx_rw, o_bx_address, o_bx_wdata} !== {m_rw[w], m_addr[w], m_wdata[w]}) begin
      errors++;
      $display("FAIL command: got rw=%b a=%h d=%h want rw=%b a=%h d=%h",
               o_bx_rw, o_bx_address, o_bx_wdata, m_rw[w], m_addr[w], m_wdata[w]);
    end
    if (drop_mid) i_request[w] = 1'b0;
    for (int d = 0; d < delay; d++) begin
      checks++;
      if (o_ready !== '0 || o_bx_request !== 1'b1 ||
          {o_bx_rw, o_bx_address, o_bx_wdata} !== {m_rw[w], m_addr[w], m_wdata[w]}) begin
        errors++;
        $display("FAIL hold: cycle %0d got rdy=%b req=%b a=%h d=%h want rdy=0 req=1 a=%h d=%h",
                 d, o_ready, o_bx_request, o_bx_address, o_bx_wdata, m_addr[w], m_wdata[w]);
      end
      step();
    end
    i_bx_rdata = rdata;
    i_bx_ready = 1'b1;
    #1;
    exp_ready = N'(1) << w;
    checks++;
    if (o_ready !== exp_ready) begin
      errors++;
      $display("FAIL ready_pulse: got %b want %b", o_ready, exp_ready);
    end
    checks++;
    if (o_rdata !== rdata) begin
      errors++;
      $display("FAIL rdata: got %h want %h", o_rdata, rdata);
    end
    step();
    i_bx_ready = 1'b0;
    if (!keep[w]) i_request[w] = 1'b0;
    model_ptr = (w + 1) % N;
    checks++;
    if (o_bx_request !== 1'b0 || o_ready !== '0) begin
      errors++;
      $display("FAIL idle_gap: got req=%b rdy=%b want 0 0", o_bx_request, o_ready);
    end
  endtask

  task automatic test_reset();
    i_reset = 1'b1;
    i_request = '0; i_rw = '0; i_address = '0; i_wdata = '0;
    i_bx_rdata = '0; i_bx_ready = 1'b0;
    #2;
    checks++;
    if ({o_bx_request, o_bx_rw, o_bx_address, o_bx_wdata, o_grant, o_ready} !== '0) begin
      errors++;
      $display("FAIL reset_state: got req=%b rw=%b a=%h d=%h g=%0d rdy=%b want all 0",
               o_bx_request, o_bx_rw, o_bx_address, o_bx_wdata, o_grant, o_ready);
    end
    do_reset();
  endtask

  task automatic test_single_write();
    do_reset();
    set_master(0, 1'b1, 32'h1000_0005, 32'd100);
    run_txn(1, 2'b00, 1'b0, $urandom);
  endtask

  task automatic test_simultaneous();
    do_reset();
    set_master(0, 1'b0, $urandom, $urandom);
    set_master(1, 1'b1, $urandom, $urandom);
    run_txn(1, 2'b00, 1'b0, $urandom);
    run_txn(1, 2'b00, 1'b0, $urandom);
  endtask

  task automatic test_alternate();
    do_reset();
    set_master(0, 1'b1, $urandom, $urandom);
    set_master(1, 1'b0, $urandom, $urandom);
    for (int t = 0; t < 4; t++) run_txn($urandom_range(0, 3), 2'b11, 1'b0, $urandom);
    do_reset();
  endtask

  task automatic test_long_read();
    do_reset();
    set_master(1, 1'b0, $urandom, $urandom);
    run_txn(50, 2'b00, 1'b0, 32'hCAFE_F00D);
  endtask

  task automatic test_reset_busy();
    do_reset();
    set_master(0, 1'b1, $urandom, $urandom);
    step();
    i_reset    = 1'b1;
    i_bx_ready = 1'b1;
    #1;
    checks++;
    if ({o_bx_request, o_bx_rw, o_bx_address, o_bx_wdata, o_grant, o_ready} !== '0) begin
      errors++;
      $display("FAIL reset_busy: got req=%b rw=%b a=%h d=%h g=%0d rdy=%b want all 0",
               o_bx_request, o_bx_rw, o_bx_address, o_bx_wdata, o_grant, o_ready);
    end
    i_bx_ready = 1'b0;
    i_request  = '0;
    step();
    i_reset   = 1'b0;
    model_ptr = 0;
    set_master(1, 1'b0, $urandom, $urandom);
    run_txn(2, 2'b00, 1'b0, $urandom);
    set_master(0, 1'b1, $urandom, $urandom);
    set_master(1, 1'b1, $urandom, $urandom);
    run_txn(1, 2'b00, 1'b0, $urandom);
    run_txn(1, 2'b00, 1'b0, $urandom);
  endtask

  task automatic test_idle_ready();
    do_reset();
    i_bx_ready = 1'b1;
    #1;
    checks++;
    if (o_ready !== '0) begin
      errors++;
      $display("FAIL idle_ready: got %b want 00", o_ready);
    end
    step();
    checks++;
    if (o_bx_request !== 1'b0) begin
      errors++;
      $display("FAIL idle_stays: got req=%b want 0", o_bx_request);
    end
    i_bx_ready = 1'b0;
    set_master(1, 1'b1, $urandom, $urandom);
    run_txn(2, 2'b00, 1'b0, $urandom);
  endtask

  task automatic test_drop_mid_busy();
    do_reset();
    set_master(0, 1'b0, $urandom, $urandom);
    run_txn(3, 2'b00, 1'b1, $urandom);
  endtask

  task automatic test_random();
    do_reset();
    for (int t = 0; t < 30; t++) begin
      for (int m = 0; m < N; m++)
        if (!i_request[m] && $urandom_range(0, 1) == 1)
          set_master(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      if (i_request == '0) begin
        int m;
        m = $urandom_range(0, N - 1);
        set_master(m, 1'($urandom_range(0, 1)), $urandom, $urandom);
      end
      run_txn($urandom_range(0, 4), N'($urandom_range(0, 3)),
              ($urandom_range(0, 7) == 0), $urandom);
    end
    do_reset();
  endtask

  initial begin
    test_reset();
    test_single_write();
    test_simultaneous();
    test_alternate();
    test_long_read();
    test_reset_busy();
    test_idle_ready();
    test_drop_mid_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
